// File: rtl/hard_disk_pkg.sv
// Shared definitions for the disk controller: controller states and the
// default geometry/timing used when the top is instantiated without overrides.
package hard_disk_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_TRACK_WIDTH  = 5;
  localparam int DEF_SECTOR_WIDTH = 8;
  localparam int DEF_LEN_WIDTH    = 8;
  localparam int DEF_SEEK_CYCLES  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_WRITE,
    ST_READ_FETCH,
    ST_READ_HOLD,
    ST_DONE
  } hd_state_e;

endpackage

// File: rtl/hd_store.sv
// Single-port platter storage: synchronous read, write-enabled, no reset so
// contents survive controller resets.
module hd_store #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read data only updates on a read, so it holds steady while the
  // controller waits for the consumer.
  always_ff @(posedge clock) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hard_disk_ctrl.sv
// Command-driven disk controller: validates a transfer, charges a seek when
// the head must move, then streams words to or from the platter store.
module hard_disk_ctrl
  import hard_disk_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int TRACK_WIDTH  = DEF_TRACK_WIDTH,
  parameter int SECTOR_WIDTH = DEF_SECTOR_WIDTH,
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH,
  parameter int SEEK_CYCLES  = DEF_SEEK_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [TRACK_WIDTH-1:0]  cmd_track,
  input  logic [SECTOR_WIDTH-1:0] cmd_sector,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rdata_valid,
  input  logic                    rdata_ready,
  output logic                    done,
  output logic                    error,
  output logic [TRACK_WIDTH-1:0]  head_track
);

  localparam int AW     = TRACK_WIDTH + SECTOR_WIDTH;
  localparam int SUM_W  = ((AW > LEN_WIDTH) ? AW : LEN_WIDTH) + 1;
  localparam int SEEK_W = (SEEK_CYCLES > 1) ? $clog2(SEEK_CYCLES) : 1;
  localparam logic [SUM_W-1:0] CAPACITY = {{(SUM_W-1){1'b0}}, 1'b1} << AW;

  hd_state_e               state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic                    is_write_q, is_write_d;
  logic [SEEK_W-1:0]       seek_cnt_q, seek_cnt_d;
  logic [TRACK_WIDTH-1:0]  head_q, head_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    wdata_ready_q, wdata_ready_d;
  logic                    rdata_valid_q, rdata_valid_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic                    mem_we, mem_re, step;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic [AW-1:0]           start_addr, addr_inc;
  logic [SUM_W-1:0]        end_sum;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    is_write_d = is_write_q;
    seek_cnt_d = seek_cnt_q;
    head_d     = head_q;
    error_d    = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    step       = 1'b0;
    start_addr = {cmd_track, cmd_sector};
    end_sum    = SUM_W'(start_addr) + SUM_W'(cmd_len);
    addr_inc   = addr_q + AW'(1);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_len == '0 || end_sum > CAPACITY) begin
            error_d = 1'b1;
          end else begin
            addr_d     = start_addr;
            rem_d      = cmd_len;
            is_write_d = cmd_write;
            if (cmd_track != head_q) begin
              state_d    = ST_SEEK;
              seek_cnt_d = SEEK_W'(SEEK_CYCLES - 1);
            end else begin
              state_d = cmd_write ? ST_WRITE : ST_READ_FETCH;
            end
          end
        end
      end
      ST_SEEK: begin
        if (seek_cnt_q == '0) begin
          head_d  = addr_q[AW-1:SECTOR_WIDTH];
          state_d = is_write_q ? ST_WRITE : ST_READ_FETCH;
        end else begin
          seek_cnt_d = seek_cnt_q - SEEK_W'(1);
        end
      end
      ST_WRITE: begin
        if (wdata_valid && wdata_ready_q) begin
          mem_we = 1'b1;
          step   = 1'b1;
        end
      end
      ST_READ_FETCH: begin
        mem_re  = 1'b1;
        state_d = ST_READ_HOLD;
      end
      ST_READ_HOLD: begin
        if (rdata_ready) begin
          step    = 1'b1;
          state_d = ST_READ_FETCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // The head follows a sector wrap onto the next track without a seek,
    // but never moves past the final word of a transfer.
    if (step) begin
      addr_d = addr_inc;
      rem_d  = rem_q - LEN_WIDTH'(1);
      if (rem_q == LEN_WIDTH'(1)) state_d = ST_DONE;
      else                        head_d  = addr_inc[AW-1:SECTOR_WIDTH];
    end

    mem_we        = mem_we && reset;
    mem_re        = mem_re && reset;
    cmd_ready_d   = (state_d == ST_IDLE);
    wdata_ready_d = (state_d == ST_WRITE);
    rdata_valid_d = (state_d == ST_READ_HOLD);
    done_d        = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      rem_q         <= '0;
      is_write_q    <= 1'b0;
      seek_cnt_q    <= '0;
      head_q        <= '0;
      cmd_ready_q   <= 1'b1;
      wdata_ready_q <= 1'b0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      is_write_q    <= is_write_d;
      seek_cnt_q    <= seek_cnt_d;
      head_q        <= head_d;
      cmd_ready_q   <= cmd_ready_d;
      wdata_ready_q <= wdata_ready_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  hd_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_store (
    .clock (clock),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr_q),
    .wdata (wdata),
    .rdata (mem_rdata)
  );

  assign cmd_ready   = cmd_ready_q;
  assign wdata_ready = wdata_ready_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_valid_q ? mem_rdata : '0;
  assign done        = done_q;
  assign error       = error_q;
  assign head_track  = head_q;

endmodule

// File: tb/tb_hard_disk_ctrl.sv
// Directed bench for hard_disk_ctrl: hand-computed expectations for writes,
// reads, seeks, sector wrap, rejected commands, back-pressure and reset abort.
module tb_hard_disk_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_track;
  logic [7:0]  cmd_sector, cmd_len;
  logic [31:0] wdata, rdata;
  logic        wdata_valid, wdata_ready, rdata_valid, rdata_ready;
  logic        done, error;
  logic [4:0]  head_track;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  hard_disk_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_track   (cmd_track),
    .cmd_sector  (cmd_sector),
    .cmd_len     (cmd_len),
    .wdata       (wdata),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .rdata_ready (rdata_ready),
    .done        (done),
    .error       (error),
    .head_track  (head_track)
  );

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one command for one edge; returns on the cycle after acceptance.
  task automatic send_cmd(input logic w, input logic [4:0] t, input logic [7:0] s, input logic [7:0] l);
    cmd_valid  = 1'b1;
    cmd_write  = w;
    cmd_track  = t;
    cmd_sector = s;
    cmd_len    = l;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_wready();
    int n = 0;
    while (!wdata_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!wdata_ready) check_output("wready_timeout", 32'(wdata_ready), 32'd1);
  endtask

  task automatic wait_rvalid();
    int n = 0;
    while (!rdata_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!rdata_valid) check_output("rvalid_timeout", 32'(rdata_valid), 32'd1);
  endtask

  task automatic write_word(input logic [31:0] v);
    wdata_valid = 1'b1;
    wdata       = v;
    @(negedge clock);
    wdata_valid = 1'b0;
  endtask

  task automatic read_word(input string tag, input logic [31:0] exp);
    wait_rvalid();
    check_output(tag, rdata, exp);
    rdata_ready = 1'b1;
    @(negedge clock);
    rdata_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_track   = '0;
    cmd_sector  = '0;
    cmd_len     = '0;
    wdata       = '0;
    wdata_valid = 1'b0;
    rdata_ready = 1'b0;
    repeat (3) @(negedge clock);

    check_output("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_output("rst_head", 32'(head_track), 32'd0);
    check_output("rst_wready", 32'(wdata_ready), 32'd0);
    check_output("rst_rvalid", 32'(rdata_valid), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_error", 32'(error), 32'd0);
    check_output("rst_rdata", rdata, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Same-track write goes straight to WRITE; done one cycle after word three.
    send_cmd(1'b1, 5'd0, 8'd0, 8'd3);
    check_output("wr_noseek_ready", 32'(wdata_ready), 32'd1);
    write_word(32'hA);
    write_word(32'hB);
    write_word(32'hC);
    check_output("wr_done", 32'(done), 32'd1);
    @(negedge clock);
    check_output("wr_done_pulse", 32'(done), 32'd0);
    check_output("wr_back_idle", 32'(cmd_ready), 32'd1);

    send_cmd(1'b0, 5'd0, 8'd0, 8'd3);
    check_output("rd_fetch_not_valid", 32'(rdata_valid), 32'd0);
    read_word("rd_word0", 32'hA);
    read_word("rd_word1", 32'hB);
    read_word("rd_word2", 32'hC);
    check_output("rd_done", 32'(done), 32'd1);
    @(negedge clock);

    // Seek from track 0 to track 3 costs four cycles before the fetch.
    send_cmd(1'b0, 5'd3, 8'd10, 8'd1);
    n = 0;
    while (head_track != 5'd3 && n < 20) begin
      n++;
      @(negedge clock);
    end
    check_output("seek_cycles", 32'(n), 32'd4);
    check_output("seek_head", 32'(head_track), 32'd3);
    check_output("seek_fetch_not_valid", 32'(rdata_valid), 32'd0);
    @(negedge clock);
    check_output("seek_then_valid", 32'(rdata_valid), 32'd1);
    rdata_ready = 1'b1;
    @(negedge clock);
    rdata_ready = 1'b0;
    check_output("seek_done", 32'(done), 32'd1);
    @(negedge clock);

    // Sector wrap: {1,255} then {2,0}, head follows to track 2.
    send_cmd(1'b1, 5'd1, 8'd255, 8'd2);
    wait_wready();
    write_word(32'h11);
    check_output("wrap_head_mid", 32'(head_track), 32'd2);
    write_word(32'h22);
    check_output("wrap_done", 32'(done), 32'd1);
    check_output("wrap_head_done", 32'(head_track), 32'd2);
    @(negedge clock);
    send_cmd(1'b0, 5'd2, 8'd0, 8'd1);
    read_word("wrap_track2_s0", 32'h22);
    check_output("wrap_rd1_done", 32'(done), 32'd1);
    @(negedge clock);
    send_cmd(1'b0, 5'd1, 8'd255, 8'd2);
    read_word("wrap_rd_a", 32'h11);
    read_word("wrap_rd_b", 32'h22);
    check_output("wrap_rd_head", 32'(head_track), 32'd2);
    @(negedge clock);

    // Last word of the disk is writable; rejected commands must not touch it.
    send_cmd(1'b1, 5'd31, 8'd255, 8'd1);
    wait_wready();
    write_word(32'h77);
    check_output("last_word_done", 32'(done), 32'd1);
    @(negedge clock);
    wdata       = 32'hDEAD;
    wdata_valid = 1'b1;
    send_cmd(1'b1, 5'd0, 8'd0, 8'd0);
    check_output("len0_error", 32'(error), 32'd1);
    check_output("len0_no_done", 32'(done), 32'd0);
    @(negedge clock);
    check_output("len0_error_pulse", 32'(error), 32'd0);
    check_output("len0_idle", 32'(cmd_ready), 32'd1);
    check_output("len0_no_wready", 32'(wdata_ready), 32'd0);
    send_cmd(1'b1, 5'd31, 8'd255, 8'd2);
    check_output("ovf_error", 32'(error), 32'd1);
    check_output("ovf_no_done", 32'(done), 32'd0);
    check_output("ovf_head", 32'(head_track), 32'd31);
    @(negedge clock);
    check_output("ovf_error_pulse", 32'(error), 32'd0);
    wdata_valid = 1'b0;
    send_cmd(1'b0, 5'd31, 8'd255, 8'd1);
    read_word("ovf_store_kept", 32'h77);
    @(negedge clock);
    send_cmd(1'b0, 5'd0, 8'd0, 8'd1);
    read_word("len0_store_kept", 32'hA);
    @(negedge clock);

    // Back-pressure: rdata held stable, no advance while rdata_ready is low.
    send_cmd(1'b0, 5'd0, 8'd1, 8'd2);
    wait_rvalid();
    for (int i = 0; i < 5; i++) begin
      check_output("stall_valid", 32'(rdata_valid), 32'd1);
      check_output("stall_data", rdata, 32'hB);
      @(negedge clock);
    end
    read_word("stall_first", 32'hB);
    read_word("stall_second", 32'hC);
    check_output("stall_done", 32'(done), 32'd1);
    @(negedge clock);

    // Reset after two of four words: no done, written words survive.
    send_cmd(1'b1, 5'd4, 8'd0, 8'd4);
    wait_wready();
    write_word(32'h41);
    write_word(32'h42);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check_output("abort_no_done", 32'(done), 32'd0);
      check_output("abort_idle", 32'(cmd_ready), 32'd1);
      check_output("abort_no_wready", 32'(wdata_ready), 32'd0);
    end
    reset = 1'b1;
    @(negedge clock);
    check_output("abort_head", 32'(head_track), 32'd0);
    check_output("abort_still_no_done", 32'(done), 32'd0);
    send_cmd(1'b0, 5'd4, 8'd0, 8'd2);
    read_word("abort_kept0", 32'h41);
    read_word("abort_kept1", 32'h42);
    check_output("abort_rd_done", 32'(done), 32'd1);
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
